// File: rtl/irq_controller_if.sv
// Interface bundle between the CPU core and irq_controller: source lines,
// instruction-boundary hints, config bus and ROM control pulses.
interface irq_controller_if #(
  parameter int unsigned NUM_IRQ = 8
);
  logic [NUM_IRQ-1:0] irq;
  logic               fetch_enable;
  logic               jump_enable;
  logic               reti;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [7:0]         cfg_wdata;
  logic [7:0]         cfg_rdata;
  logic               interrupt_jump;
  logic               interrupt_clear_status;
  logic [2:0]         irq_id;
  logic               in_service;

  modport master (
    output irq, fetch_enable, jump_enable, reti, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rdata, interrupt_jump, interrupt_clear_status, irq_id, in_service
  );

  modport slave (
    input  irq, fetch_enable, jump_enable, reti, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rdata, interrupt_jump, interrupt_clear_status, irq_id, in_service
  );
endinterface

// File: rtl/irq_controller.sv
// Non-nesting interrupt controller: edge-latched sources, mask + global enable,
// fixed priority (index 0 highest), one jump per handler, released by RETI.
module irq_controller #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  irq_controller_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StService} state_e;

  state_e             state_q;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic               gie_q;
  logic [2:0]         irq_id_q;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] winner_oh;
  logic [NUM_IRQ-1:0] pend_clr;
  logic [NUM_IRQ-1:0] pending_d;
  logic [2:0]         winner;
  logic               take;
  logic               in_service;

  assign in_service = (state_q == StService);

  always_comb begin
    rise      = bus.irq & ~irq_prev_q;
    eligible  = pending_q & ~mask_q;
    winner    = '0;
    winner_oh = '0;
    // Scan high to low so the lowest eligible index is the last one kept.
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner       = 3'(i);
        winner_oh    = '0;
        winner_oh[i] = 1'b1;
      end
    end
    // A taken branch would be lost by the ROM, so only jump on a plain fetch.
    take = ~rst & (state_q == StIdle) & gie_q & (|eligible) &
           bus.fetch_enable & ~bus.jump_enable;
    pend_clr = winner_oh & {NUM_IRQ{take}};
    if (bus.cfg_we && bus.cfg_addr == 2'd1) begin
      pend_clr = pend_clr | bus.cfg_wdata[NUM_IRQ-1:0];
    end
    // New edges override same-cycle clears.
    pending_d = (pending_q & ~pend_clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      gie_q      <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      irq_prev_q <= bus.irq;
      pending_q  <= pending_d;
      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          2'd0:    mask_q <= bus.cfg_wdata[NUM_IRQ-1:0];
          2'd2:    gie_q  <= bus.cfg_wdata[0];
          default: ;
        endcase
      end
      case (state_q)
        StIdle: begin
          if (take) begin
            irq_id_q <= winner;
            state_q  <= StService;
          end
        end
        StService: begin
          if (bus.reti) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.interrupt_jump         = take;
  assign bus.interrupt_clear_status = ~rst & in_service & bus.reti;
  assign bus.irq_id                 = irq_id_q;
  assign bus.in_service             = in_service;

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata = 8'(mask_q);
      2'd1:    bus.cfg_rdata = 8'(pending_q);
      2'd2:    bus.cfg_rdata = {4'b0, in_service, irq_id_q};
      default: bus.cfg_rdata = '0;
    endcase
  end

endmodule
